multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 15: maximum consecutive cycles a memory state may wait for mem_ready before faulting.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port opcode  input  6  instruction[31:26] from the instruction register.
REQ-005 SHALL have port mem_ready  input  1  memory access completes this cycle.
REQ-006 SHALL have outputs pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  multicycle datapath strobes and selects.
REQ-007 SHALL have outputs alu_src_b, alu_op, pc_source  output  2 each  mux selects and ALU op class (alu_op 00 add, 01 sub, 10 funct).
REQ-008 SHALL have outputs halted, error  output  1 each  sticky status flags.
REQ-009 SHALL have output state  output  4  current FSM state, for debug.

Function
REQ-010 SHALL implement states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, RWB, EXEC_I, IWB, BRANCH, JUMP, HALT, ERR; any output not listed for a state SHALL be 0.
REQ-011 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write and pc_write SHALL equal mem_ready; on mem_ready go to DECODE, else stay.
REQ-012 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; SHALL latch opcode internally; next state: 000000->EXEC_R, 100011/101011->MEMADR, 001000/001001->EXEC_I, 000100->BRANCH, 000010->JUMP, 111111->HALT, other->ERR.
REQ-013 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; latched opcode lw->MEMRD, sw->MEMWR.
REQ-014 MEMRD: mem_read=1, i_or_d=1; MEMWR: mem_write=1, i_or_d=1; both stay until mem_ready, then MEMRD->MEMWB, MEMWR->FETCH.
REQ-015 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
REQ-016 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> RWB; RWB: reg_write=1, reg_dst=1 -> FETCH.
REQ-017 EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00 -> IWB; IWB: reg_write=1, reg_dst=0 -> FETCH.
REQ-018 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
REQ-019 JUMP: pc_write=1, pc_source=10 -> FETCH.
REQ-020 HALT: halted=1, all strobes 0, SHALL remain until reset; ERR: error=1, same stickiness.
REQ-021 Zero-wait latency in cycles (FETCH to next FETCH): R/addi/addiu 4, lw 5, sw 4, beq 3, j 3; each mem_ready-low cycle in FETCH/MEMRD/MEMWR adds one.
REQ-022 Wait counter SHALL count consecutive mem_ready-low cycles in FETCH/MEMRD/MEMWR, clear on any state change, and on reaching WAIT_LIMIT force ERR next cycle; mem_ready SHALL be ignored in all other states.
REQ-023 mem_ready and counter reaching WAIT_LIMIT in the same cycle: mem_ready SHALL win (normal transition).
REQ-024 Opcode changes after DECODE SHALL not affect the current instruction's sequence.

Reset
REQ-025 While rst_n=0 at a rising edge: state<=FETCH, wait counter<=0, latched opcode<=0, halted/error cleared.
REQ-026 While rst_n=0 all strobe outputs (mem_read, mem_write, reg_write, ir_write, pc_write, pc_write_cond) SHALL be forced 0 combinationally; selects 0; state output reads FETCH.
REQ-027 Reset mid-instruction SHALL abandon it with no further writes; first post-reset cycle is FETCH.

Structure
REQ-028 Shared package mc_pkg SHALL hold state encoding, opcode constants, alu_op, alu_src_b and pc_source codes.
REQ-029 Wait counter SHALL be sub-module mc_wait_counter (inputs clk, rst_n, enable, clear; output at_limit).
REQ-030 Next-state and output decode SHALL be combinational from registered state, latched opcode, mem_ready and rst_n.

Verification
REQ-031 R-type: opcode 000000, mem_ready=1 -> states FETCH,DECODE,EXEC_R,RWB; reg_write=1, reg_dst=1 only in RWB.
REQ-032 lw with 2 wait cycles in MEMRD: opcode 100011 -> 7 cycles, mem_to_reg=1 and reg_write=1 exactly one cycle.
REQ-033 beq then j: opcode 000100 gives pc_write_cond=1, pc_source=01 in cycle 3; 000010 gives pc_write=1, pc_source=10 in cycle 3.
REQ-034 Timeout: mem_ready held 0 in FETCH, WAIT_LIMIT=4 -> ERR after 4 wait cycles, error=1 sticky, strobes 0.
REQ-035 Halt/illegal: opcode 111111 -> HALT, halted=1; opcode 010101 -> ERR.
REQ-036 Reset during MEMWR with mem_ready=0: mem_write drops same cycle rst_n=0, state FETCH after release.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control unit: state encoding,
// opcode constants and the datapath select/op codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_RWB    = 4'd7,
    S_EXEC_I = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12,
    S_ERR    = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFS = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that wait on mem_ready and are therefore subject to the timeout.
  function automatic logic is_mem_wait(state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_wait_counter.sv
// Counts consecutive stalled cycles in a memory-wait state. at_limit is high
// when the current cycle is the LIMIT-th consecutive stalled cycle, so a
// stall in that cycle must fault.
module mc_wait_counter #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic at_limit
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_q, count_d;

  // Next count: clear wins, otherwise count stalls up to the last value.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !at_limit) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_limit = (count_q == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM. Sequences fetch/decode/execute/memory/
// writeback, times out stalled memory accesses, and parks in HALT or ERR
// until reset.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       halted,
  output logic       error,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  logic       at_limit;
  logic       wait_en;
  logic       wait_clr;

  // Counter tracks stalls only while actually waiting; any state change
  // (including reset) starts the count afresh.
  assign wait_en  = rst_n && is_mem_wait(state_q) && !mem_ready;
  assign wait_clr = !rst_n || (state_d != state_q);

  mc_wait_counter #(
    .LIMIT(WAIT_LIMIT)
  ) u_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (wait_en),
    .clear   (wait_clr),
    .at_limit(at_limit)
  );

  // State register and opcode latched at DECODE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Next-state decode; mem_ready beats a timeout in the same cycle.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)     state_d = S_DECODE;
        else if (at_limit) state_d = S_ERR;
      end
      S_DECODE: begin
        opcode_d = opcode;
        case (opcode)
          OP_RTYPE:         state_d = S_EXEC_R;
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_ADDI, OP_ADDIU: state_d = S_EXEC_I;
          OP_BEQ:           state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          OP_HALT:          state_d = S_HALT;
          default:          state_d = S_ERR;
        endcase
      end
      S_MEMADR: begin
        if (opcode_q == OP_LW)      state_d = S_MEMRD;
        else if (opcode_q == OP_SW) state_d = S_MEMWR;
        else                        state_d = S_ERR;
      end
      S_MEMRD: begin
        if (mem_ready)     state_d = S_MEMWB;
        else if (at_limit) state_d = S_ERR;
      end
      S_MEMWR: begin
        if (mem_ready)     state_d = S_FETCH;
        else if (at_limit) state_d = S_ERR;
      end
      S_EXEC_R: state_d = S_RWB;
      S_EXEC_I: state_d = S_IWB;
      S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_ERR;
    endcase
    if (!rst_n) begin
      state_d  = S_FETCH;
      opcode_d = '0;
    end
  end

  // Per-state datapath controls; everything is forced low while in reset.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    halted        = 1'b0;
    error         = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_BOFS;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_IWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      S_HALT:  halted = 1'b1;
      S_ERR:   error  = 1'b1;
      default: ;
    endcase
    if (!rst_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      alu_op        = ALU_ADD;
      pc_source     = PCSRC_ALU;
      halted        = 1'b0;
      error         = 1'b0;
    end
  end

  assign state = rst_n ? state_q : S_FETCH;

endmodule
